// File: rtl/spram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Package     : spram_arb_pkg
// Description : Shared constants and the RAM command bundle used by the
//               two-port SPRAM arbiter.
//               RAM_AW - word address width of the 32768x32 array
//               RAM_DW - data width
//               RAM_BW - number of byte lanes
// Revision    : 1.0 - initial release
// ============================================================================
package spram_arb_pkg;

    localparam int RAM_AW = 15;
    localparam int RAM_DW = 32;
    localparam int RAM_BW = 4;

    // One requester's command as presented to the RAM.
    typedef struct packed {
        logic [RAM_AW-1:0] addr;
        logic              we;
        logic [RAM_BW-1:0] be;
        logic [RAM_DW-1:0] wdata;
    } ram_cmd_t;

endpackage : spram_arb_pkg
`default_nettype wire

// File: rtl/spram_arb_pick.sv
`default_nettype none
// ============================================================================
// Module      : spram_arb_pick
// Description : Purely combinational grant selection for two requesters.
//               FIXED_PRIO=0 : round-robin on ties, using the last winner.
//               FIXED_PRIO=1 : port 0 wins ties until the burst counter
//                              reaches MAX_BURST, then port 1 wins once.
// Ports       : i_req   [1:0] - request vector (bit N = port N)
//               i_last        - port that won the most recent grant
//               i_burst [3:0] - consecutive port-0 grants while port 1 waits
//               o_gnt   [1:0] - grant vector, one-hot or zero
// Revision    : 1.0 - initial release
// ============================================================================
module spram_arb_pick #(
    parameter int FIXED_PRIO = 0,
    parameter int MAX_BURST  = 4
) (
    input  logic [1:0] i_req,
    input  logic       i_last,
    input  logic [3:0] i_burst,
    output logic [1:0] o_gnt
);

    localparam logic [3:0] c_MAX_BURST = 4'(MAX_BURST);

    // Winner when both ports request in the same cycle.
    logic [1:0] w_tie;

    generate
        if (FIXED_PRIO != 0) begin : g_fixed
            // Only the burst bound matters; the last winner is irrelevant.
            logic w_unused_last;
            assign w_unused_last = i_last;
            assign w_tie = (i_burst == c_MAX_BURST) ? 2'b10 : 2'b01;
        end else begin : g_rr
            // Burst count is tracked by the top level regardless of mode,
            // but round-robin never consults it.
            logic w_unused_burst;
            assign w_unused_burst = ^i_burst;
            assign w_tie = i_last ? 2'b01 : 2'b10;
        end
    endgenerate

    always_comb begin
        o_gnt = 2'b00;
        case (i_req)
            2'b01:   o_gnt = 2'b01;
            2'b10:   o_gnt = 2'b10;
            2'b11:   o_gnt = w_tie;
            default: o_gnt = 2'b00;
        endcase
    end

endmodule : spram_arb_pick
`default_nettype wire

// File: rtl/spram_arbiter2.sv
`default_nettype none
// ============================================================================
// Module      : spram_arbiter2
// Description : Shares one 32768x32 single-port SPRAM between two requesters.
//               At most one request is granted per cycle; the RAM command for
//               the winner is driven combinationally in the same cycle and
//               read data is flagged valid to the winner one cycle later.
// Parameters  : FIXED_PRIO - 0 round-robin, 1 port-0 priority with bound
//               MAX_BURST  - max consecutive port-0 grants while port 1 waits
// Ports       : clk_i, rst_i (async, active-high)
//               pN_req_i/we_i/addr_i/be_i/wdata_i - port N command
//               pN_gnt_o     - command accepted this cycle (combinational)
//               pN_rvalid_o  - read data valid (registered)
//               pN_rdata_o   - passthrough of ram_rd_data_i
//               ram_addr_o/wr_en_o/mask_we_o/wr_data_o - SPRAM command
//               ram_rd_data_i - SPRAM read data, one cycle after address
// Revision    : 1.0 - initial release
// ============================================================================
module spram_arbiter2
    import spram_arb_pkg::*;
#(
    parameter int FIXED_PRIO = 0,
    parameter int MAX_BURST  = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              p0_req_i,
    input  logic              p0_we_i,
    input  logic [RAM_AW-1:0] p0_addr_i,
    input  logic [RAM_BW-1:0] p0_be_i,
    input  logic [RAM_DW-1:0] p0_wdata_i,
    output logic              p0_gnt_o,
    output logic              p0_rvalid_o,
    output logic [RAM_DW-1:0] p0_rdata_o,

    input  logic              p1_req_i,
    input  logic              p1_we_i,
    input  logic [RAM_AW-1:0] p1_addr_i,
    input  logic [RAM_BW-1:0] p1_be_i,
    input  logic [RAM_DW-1:0] p1_wdata_i,
    output logic              p1_gnt_o,
    output logic              p1_rvalid_o,
    output logic [RAM_DW-1:0] p1_rdata_o,

    output logic [RAM_AW-1:0] ram_addr_o,
    output logic              ram_wr_en_o,
    output logic [RAM_BW-1:0] ram_mask_we_o,
    output logic [RAM_DW-1:0] ram_wr_data_o,
    input  logic [RAM_DW-1:0] ram_rd_data_i
);

    localparam logic [3:0] c_MAX_BURST = 4'(MAX_BURST);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic              r_last;        // port of the most recent grant
    logic [3:0]        r_burst;       // port-0 grants while port 1 waits
    logic [1:0]        r_rv;          // read response pending, per port
    logic [RAM_AW-1:0] r_addr_hold;   // last granted address
    logic [RAM_DW-1:0] r_wdata_hold;  // last granted write data

    // ------------------------------------------------------------------
    // Grant selection
    // ------------------------------------------------------------------
    logic [1:0] w_req;
    logic [1:0] w_gnt;
    logic       w_any;
    ram_cmd_t   w_cmd0;
    ram_cmd_t   w_cmd1;
    ram_cmd_t   w_sel;

    // Requests are masked during reset so no grant, and in particular no
    // write strobe, can reach the RAM while rst_i is high.
    assign w_req = {p1_req_i, p0_req_i} & {2{~rst_i}};

    spram_arb_pick #(
        .FIXED_PRIO (FIXED_PRIO),
        .MAX_BURST  (MAX_BURST)
    ) u_pick (
        .i_req   (w_req),
        .i_last  (r_last),
        .i_burst (r_burst),
        .o_gnt   (w_gnt)
    );

    assign w_any = |w_gnt;

    always_comb begin
        w_cmd0.addr  = p0_addr_i;
        w_cmd0.we    = p0_we_i;
        w_cmd0.be    = p0_be_i;
        w_cmd0.wdata = p0_wdata_i;
        w_cmd1.addr  = p1_addr_i;
        w_cmd1.we    = p1_we_i;
        w_cmd1.be    = p1_be_i;
        w_cmd1.wdata = p1_wdata_i;
        w_sel        = w_gnt[1] ? w_cmd1 : w_cmd0;
    end

    // ------------------------------------------------------------------
    // RAM command: live from the winner, otherwise the address and data
    // buses park on their last granted values so they do not toggle.
    // ------------------------------------------------------------------
    assign ram_addr_o    = w_any ? w_sel.addr  : r_addr_hold;
    assign ram_wr_data_o = w_any ? w_sel.wdata : r_wdata_hold;
    assign ram_wr_en_o   = w_any & w_sel.we;
    assign ram_mask_we_o = w_any ? w_sel.be : '0;

    // ------------------------------------------------------------------
    // Port outputs
    // ------------------------------------------------------------------
    assign p0_gnt_o    = w_gnt[0];
    assign p1_gnt_o    = w_gnt[1];
    assign p0_rvalid_o = r_rv[0];
    assign p1_rvalid_o = r_rv[1];
    assign p0_rdata_o  = ram_rd_data_i;
    assign p1_rdata_o  = ram_rd_data_i;

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_last       <= 1'b1;      // port 0 wins the first tie
            r_burst      <= 4'd0;
            r_rv         <= 2'b00;
            r_addr_hold  <= '0;
            r_wdata_hold <= '0;
        end else begin
            if (w_any) begin
                r_last       <= w_gnt[1];
                r_addr_hold  <= w_sel.addr;
                r_wdata_hold <= w_sel.wdata;
            end

            // One grant per cycle, so responses naturally return in order.
            r_rv[0] <= w_gnt[0] & ~p0_we_i;
            r_rv[1] <= w_gnt[1] & ~p1_we_i;

            // Counts only while port 1 is actually waiting; any cycle
            // without a port-1 request, or a port-1 grant, restarts it.
            if (!p1_req_i || w_gnt[1]) begin
                r_burst <= 4'd0;
            end else if (w_gnt[0] && (r_burst != c_MAX_BURST)) begin
                r_burst <= r_burst + 4'd1;
            end
        end
    end

endmodule : spram_arbiter2
`default_nettype wire

// File: tb/tb_spram_arbiter2.sv
`default_nettype none
// ============================================================================
// Module      : tb_spram_arbiter2
// Description : Self-checking bench for spram_arbiter2. Two instances share
//               the stimulus: one round-robin, one fixed priority with
//               MAX_BURST=3. Each has its own behavioural SPRAM. Expected
//               read responses are queued at grant time and popped when due.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spram_arbiter2;

    logic clk;
    logic rst;

    logic        p0_req, p0_we, p1_req, p1_we;
    logic [14:0] p0_addr, p1_addr;
    logic [3:0]  p0_be, p1_be;
    logic [31:0] p0_wdata, p1_wdata;

    // Round-robin instance signals
    logic        rr_p0_gnt, rr_p1_gnt, rr_p0_rv, rr_p1_rv, rr_we;
    logic [31:0] rr_p0_rd, rr_p1_rd, rr_wd;
    logic [14:0] rr_addr;
    logic [3:0]  rr_mask;
    bit   [31:0] rr_ramrd;
    // Fixed-priority instance signals
    logic        fp_p0_gnt, fp_p1_gnt, fp_p0_rv, fp_p1_rv, fp_we;
    logic [31:0] fp_p0_rd, fp_p1_rd, fp_wd;
    logic [14:0] fp_addr;
    logic [3:0]  fp_mask;
    bit   [31:0] fp_ramrd;

    spram_arbiter2 #(.FIXED_PRIO(0), .MAX_BURST(4)) u_rr (
        .clk_i(clk), .rst_i(rst),
        .p0_req_i(p0_req), .p0_we_i(p0_we), .p0_addr_i(p0_addr), .p0_be_i(p0_be),
        .p0_wdata_i(p0_wdata), .p0_gnt_o(rr_p0_gnt), .p0_rvalid_o(rr_p0_rv), .p0_rdata_o(rr_p0_rd),
        .p1_req_i(p1_req), .p1_we_i(p1_we), .p1_addr_i(p1_addr), .p1_be_i(p1_be),
        .p1_wdata_i(p1_wdata), .p1_gnt_o(rr_p1_gnt), .p1_rvalid_o(rr_p1_rv), .p1_rdata_o(rr_p1_rd),
        .ram_addr_o(rr_addr), .ram_wr_en_o(rr_we), .ram_mask_we_o(rr_mask),
        .ram_wr_data_o(rr_wd), .ram_rd_data_i(rr_ramrd)
    );

    spram_arbiter2 #(.FIXED_PRIO(1), .MAX_BURST(3)) u_fp (
        .clk_i(clk), .rst_i(rst),
        .p0_req_i(p0_req), .p0_we_i(p0_we), .p0_addr_i(p0_addr), .p0_be_i(p0_be),
        .p0_wdata_i(p0_wdata), .p0_gnt_o(fp_p0_gnt), .p0_rvalid_o(fp_p0_rv), .p0_rdata_o(fp_p0_rd),
        .p1_req_i(p1_req), .p1_we_i(p1_we), .p1_addr_i(p1_addr), .p1_be_i(p1_be),
        .p1_wdata_i(p1_wdata), .p1_gnt_o(fp_p1_gnt), .p1_rvalid_o(fp_p1_rv), .p1_rdata_o(fp_p1_rd),
        .ram_addr_o(fp_addr), .ram_wr_en_o(fp_we), .ram_mask_we_o(fp_mask),
        .ram_wr_data_o(fp_wd), .ram_rd_data_i(fp_ramrd)
    );

    // Behavioural SPRAMs: byte-masked write, registered read.
    bit [31:0] mem_rr [0:32767];
    bit [31:0] mem_fp [0:32767];

    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (rr_we && rr_mask[k]) mem_rr[rr_addr][8*k +: 8] <= rr_wd[8*k +: 8];
            if (fp_we && fp_mask[k]) mem_fp[fp_addr][8*k +: 8] <= fp_wd[8*k +: 8];
        end
        rr_ramrd <= mem_rr[rr_addr];
        fp_ramrd <= mem_fp[fp_addr];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Scoreboard and counters
    // ------------------------------------------------------------------
    typedef struct {
        int          due;
        int          port;
        logic [31:0] data;
    } rsp_t;

    rsp_t        q_rr[$];
    rsp_t        q_fp[$];
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    logic [31:0] exp_rd0, exp_rd1;     // expected contents at p0/p1 read address
    logic [14:0] hold_addr [2];
    logic [31:0] hold_wd   [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%08h expected=%08h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_dut(input string nm, input int d, input logic [1:0] e,
                             input logic [1:0] gnt, input logic [1:0] rv,
                             input logic [31:0] rd0, input logic [31:0] rd1,
                             input logic we, input logic [3:0] mask,
                             input logic [14:0] addr, input logic [31:0] wd);
        logic [14:0] ea;
        logic        ewe;
        logic [3:0]  em;
        logic [31:0] ewd;
        logic [1:0]  erv;
        rsp_t        r;
        if (e[0]) begin
            ea = p0_addr; ewe = p0_we; em = p0_be; ewd = p0_wdata;
        end else if (e[1]) begin
            ea = p1_addr; ewe = p1_we; em = p1_be; ewd = p1_wdata;
        end else begin
            ea = hold_addr[d]; ewe = 1'b0; em = 4'h0; ewd = hold_wd[d];
        end
        if (|e) begin
            hold_addr[d] = ea;
            hold_wd[d]   = ewd;
        end
        chk({nm, ".gnt"},      32'(gnt),  32'(e));
        chk({nm, ".wr_en"},    32'(we),   32'(ewe));
        chk({nm, ".mask"},     32'(mask), 32'(em));
        chk({nm, ".addr"},     32'(addr), 32'(ea));
        chk({nm, ".wr_data"},  wd,        ewd);

        // Response due this cycle?
        erv = 2'b00;
        if (d == 0) begin
            if (q_rr.size() > 0 && q_rr[0].due == cyc) begin
                r = q_rr.pop_front();
                erv[r.port] = 1'b1;
                chk({nm, ".rdata"}, (r.port == 0) ? rd0 : rd1, r.data);
            end
        end else begin
            if (q_fp.size() > 0 && q_fp[0].due == cyc) begin
                r = q_fp.pop_front();
                erv[r.port] = 1'b1;
                chk({nm, ".rdata"}, (r.port == 0) ? rd0 : rd1, r.data);
            end
        end
        chk({nm, ".rvalid"}, 32'(rv), 32'(erv));

        // Queue responses for reads granted now.
        if (e[0] && !p0_we) begin
            r.due = cyc + 1; r.port = 0; r.data = exp_rd0;
            if (d == 0) q_rr.push_back(r); else q_fp.push_back(r);
        end
        if (e[1] && !p1_we) begin
            r.due = cyc + 1; r.port = 1; r.data = exp_rd1;
            if (d == 0) q_rr.push_back(r); else q_fp.push_back(r);
        end
    endtask

    // One clock cycle: sample at the falling edge, return just after the
    // next rising edge so the caller can drive new inputs.
    task automatic tick(input logic [1:0] e_rr, input logic [1:0] e_fp);
        @(negedge clk);
        cyc++;
        check_dut("rr", 0, e_rr, {rr_p1_gnt, rr_p0_gnt}, {rr_p1_rv, rr_p0_rv},
                  rr_p0_rd, rr_p1_rd, rr_we, rr_mask, rr_addr, rr_wd);
        check_dut("fp", 1, e_fp, {fp_p1_gnt, fp_p0_gnt}, {fp_p1_rv, fp_p0_rv},
                  fp_p0_rd, fp_p1_rd, fp_we, fp_mask, fp_addr, fp_wd);
        @(posedge clk);
        #1;
    endtask

    task automatic drv0(input logic req, input logic we, input logic [14:0] a,
                        input logic [3:0] be, input logic [31:0] wd);
        p0_req = req; p0_we = we; p0_addr = a; p0_be = be; p0_wdata = wd;
    endtask

    task automatic drv1(input logic req, input logic we, input logic [14:0] a,
                        input logic [3:0] be, input logic [31:0] wd);
        p1_req = req; p1_we = we; p1_addr = a; p1_be = be; p1_wdata = wd;
    endtask

    task automatic model_reset();
        q_rr.delete();
        q_fp.delete();
        hold_addr[0] = '0; hold_addr[1] = '0;
        hold_wd[0]   = '0; hold_wd[1]   = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        exp_rd0 = '0;
        exp_rd1 = '0;
        drv0(1'b0, 1'b0, 15'h0, 4'h0, 32'h0);
        drv1(1'b0, 1'b0, 15'h0, 4'h0, 32'h0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;

        // Reset state: everything zero, rdata passes the RAM through.
        chk("rr.p0_rdata_pass", rr_p0_rd, rr_ramrd);
        chk("fp.p1_rdata_pass", fp_p1_rd, fp_ramrd);
        tick(2'b00, 2'b00);
        rst = 1'b0;
        tick(2'b00, 2'b00);

        // Port-0 write to 0x1234, then idle: address parks on 0x1234.
        drv0(1'b1, 1'b1, 15'h1234, 4'hF, 32'hCAFE_F00D);
        tick(2'b01, 2'b01);
        drv0(1'b0, 1'b0, 15'h1234, 4'h0, 32'h0);
        tick(2'b00, 2'b00);
        tick(2'b00, 2'b00);

        // Full write, partial write, read back -> 0x1122BEEF.
        drv0(1'b1, 1'b1, 15'h4001, 4'hF, 32'h1122_3344);
        tick(2'b01, 2'b01);
        drv0(1'b1, 1'b1, 15'h4001, 4'b0011, 32'hDEAD_BEEF);
        tick(2'b01, 2'b01);
        exp_rd0 = 32'h1122_BEEF;
        drv0(1'b1, 1'b0, 15'h4001, 4'h0, 32'h0);
        tick(2'b01, 2'b01);
        // Zero byte-enable write is granted but changes nothing.
        drv0(1'b1, 1'b1, 15'h4001, 4'h0, 32'hFFFF_FFFF);
        tick(2'b01, 2'b01);
        drv0(1'b1, 1'b0, 15'h4001, 4'h0, 32'h0);
        tick(2'b01, 2'b01);
        drv0(1'b0, 1'b0, 15'h4001, 4'h0, 32'h0);
        tick(2'b00, 2'b00);

        // Preload the two read locations.
        drv0(1'b1, 1'b1, 15'h0010, 4'hF, 32'hA5A5_0010);
        tick(2'b01, 2'b01);
        drv0(1'b0, 1'b0, 15'h0010, 4'h0, 32'h0);
        drv1(1'b1, 1'b1, 15'h7FF0, 4'hF, 32'h5A5A_7FF0);
        tick(2'b10, 2'b10);

        // Both ports reading continuously for 12 cycles.
        exp_rd0 = 32'hA5A5_0010;
        exp_rd1 = 32'h5A5A_7FF0;
        drv0(1'b1, 1'b0, 15'h0010, 4'h0, 32'h0);
        drv1(1'b1, 1'b0, 15'h7FF0, 4'h0, 32'h0);
        for (int i = 0; i < 12; i++) begin
            tick((i % 2 == 0) ? 2'b01 : 2'b10, (i % 4 == 3) ? 2'b10 : 2'b01);
        end

        // Port 1 drops mid-burst then reasserts: burst restarts.
        tick(2'b01, 2'b01);
        tick(2'b10, 2'b01);
        p1_req = 1'b0;
        tick(2'b01, 2'b01);
        p1_req = 1'b1;
        tick(2'b10, 2'b01);
        tick(2'b01, 2'b01);
        tick(2'b10, 2'b01);
        tick(2'b01, 2'b10);
        drv0(1'b0, 1'b0, 15'h0010, 4'h0, 32'h0);
        drv1(1'b0, 1'b0, 15'h7FF0, 4'h0, 32'h0);
        tick(2'b00, 2'b00);

        // Reset in the cycle after a port-1 read grant.
        drv1(1'b1, 1'b0, 15'h7FF0, 4'h0, 32'h0);
        tick(2'b10, 2'b10);
        rst = 1'b1;
        model_reset();
        drv0(1'b1, 1'b1, 15'h0020, 4'hF, 32'h1234_5678);
        tick(2'b00, 2'b00);
        rst = 1'b0;
        tick(2'b01, 2'b01);
        drv0(1'b0, 1'b0, 15'h0020, 4'h0, 32'h0);
        tick(2'b10, 2'b10);
        drv1(1'b0, 1'b0, 15'h7FF0, 4'h0, 32'h0);
        exp_rd0 = 32'h1234_5678;
        drv0(1'b1, 1'b0, 15'h0020, 4'h0, 32'h0);
        tick(2'b01, 2'b01);
        drv0(1'b0, 1'b0, 15'h0020, 4'h0, 32'h0);
        tick(2'b00, 2'b00);
        tick(2'b00, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_spram_arbiter2
`default_nettype wire
